// File: rtl/fetch_decode_stage_if.sv
// rtl/fetch_decode_stage_if.sv - instruction-memory request/acknowledge bus
//
// Purpose: groups the fetch-side instruction-memory handshake.
// Signals:
//   imem_addr  [ADDR_W-1:0]  word address (fetch -> memory)
//   imem_req                 fetch request (fetch -> memory)
//   imem_ack                 imem_rdata valid for imem_addr this cycle (memory -> fetch)
//   imem_rdata [15:0]        instruction word (memory -> fetch)
// Modports: master = fetch stage, slave = instruction memory.
interface fetch_decode_stage_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_req;
    logic              imem_ack;
    logic [15:0]       imem_rdata;

    modport master (
        output imem_addr,
        output imem_req,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_req,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - instruction fetch and IF/ID stage with skid buffer
//
// Purpose: owns the PC, runs the instruction-memory handshake, holds the
// fetched word in IF/ID and splits it into decode fields. A one-entry skid
// buffer absorbs a word that arrives while decode is stalled.
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   imem            instruction-memory bus (master side)
//   stall           decode cannot accept; IF/ID holds
//   redirect        branch/jump taken; flush and refetch from redirect_pc
//   redirect_pc     new fetch address
//   id_valid        IF/ID holds a live instruction
//   id_pc, id_instr address and raw word in IF/ID
//   opcode, rd, rs, imm_8b, imm_5b, imm_5or8  field slices of id_instr
module fetch_decode_stage #(
    parameter int              ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    fetch_decode_stage_if.master imem,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              id_valid,
    output logic [ADDR_W-1:0] id_pc,
    output logic [15:0]       id_instr,
    output logic [4:0]        opcode,
    output logic [2:0]        rd,
    output logic [2:0]        rs,
    output logic [7:0]        imm_8b,
    output logic [4:0]        imm_5b,
    output logic              imm_5or8
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              req;
    // Skid contents are live exactly while state == FULL.
    logic [ADDR_W-1:0] skid_pc;
    logic [15:0]       skid_instr;

    assign imem.imem_addr = pc;
    assign imem.imem_req  = req;

    assign opcode   = id_instr[15:11];
    assign rd       = id_instr[10:8];
    assign rs       = id_instr[7:5];
    assign imm_8b   = id_instr[7:0];
    assign imm_5b   = id_instr[4:0];
    assign imm_5or8 = id_instr[15];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            req        <= 1'b0;
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_instr   <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (redirect) begin
            // Flush wins over stall and over any word acked this cycle.
            state    <= REQ;
            req      <= 1'b1;
            pc       <= redirect_pc;
            id_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    req   <= 1'b1;
                end
                REQ: begin
                    if (imem.imem_ack) begin
                        pc <= pc + 1'b1;
                        if (!id_valid || !stall) begin
                            id_instr <= imem.imem_rdata;
                            id_pc    <= pc;
                            id_valid <= 1'b1;
                        end else begin
                            // IF/ID is blocked: park the word and stop requesting.
                            skid_instr <= imem.imem_rdata;
                            skid_pc    <= pc;
                            state      <= FULL;
                            req        <= 1'b0;
                        end
                    end else if (id_valid && !stall) begin
                        id_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (!stall) begin
                        id_instr <= skid_instr;
                        id_pc    <= skid_pc;
                        id_valid <= 1'b1;
                        state    <= REQ;
                        req      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// tb/tb_fetch_decode_stage.sv - self-checking bench for fetch_decode_stage
module tb_fetch_decode_stage;

    localparam int ADDR_W = 8;
    localparam logic [ADDR_W-1:0] RST_PC = 8'h00;

    logic              clk;
    logic              rst;
    logic              stall;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              id_valid;
    logic [ADDR_W-1:0] id_pc;
    logic [15:0]       id_instr;
    logic [4:0]        opcode;
    logic [2:0]        rd;
    logic [2:0]        rs;
    logic [7:0]        imm_8b;
    logic [4:0]        imm_5b;
    logic              imm_5or8;

    fetch_decode_stage_if #(.ADDR_W(ADDR_W)) imem_bus ();

    fetch_decode_stage #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (imem_bus),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_instr    (id_instr),
        .opcode      (opcode),
        .rd          (rd),
        .rs          (rs),
        .imm_8b      (imm_8b),
        .imm_5b      (imm_5b),
        .imm_5or8    (imm_5or8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: memory image, next fetch address, and the ordered list
    // of acked words not yet consumed by decode (front = what IF/ID shows).
    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [15:0]       ins;
    } ent_t;

    logic [15:0]       mem [0:255];
    ent_t              q [$];
    logic [ADDR_W-1:0] m_pc;
    bit                m_idle;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic compare_all();
        ent_t f;
        check("imem_addr", imem_bus.imem_addr, m_pc);
        check("imem_req", imem_bus.imem_req, (!m_idle && q.size() < 2));
        check("id_valid", id_valid, q.size() > 0);
        if (q.size() > 0) begin
            f = q[0];
            check("id_pc", id_pc, f.pc);
            check("id_instr", id_instr, f.ins);
            check("opcode", opcode, f.ins[15:11]);
            check("rd", rd, f.ins[10:8]);
            check("rs", rs, f.ins[7:5]);
            check("imm_8b", imm_8b, f.ins[7:0]);
            check("imm_5b", imm_5b, f.ins[4:0]);
            check("imm_5or8", imm_5or8, f.ins[15]);
        end
    endtask

    // One clock with the given inputs; model is advanced, then outputs compared.
    task automatic cycle(input bit a, input bit s, input bit r, input logic [ADDR_W-1:0] rp);
        bit   req_now;
        ent_t e;
        rst                 = 1'b0;
        stall               = s;
        redirect            = r;
        redirect_pc         = rp;
        imem_bus.imem_ack   = a;
        imem_bus.imem_rdata = a ? mem[imem_bus.imem_addr] : 16'($urandom);
        req_now = !m_idle && q.size() < 2;
        if (r) begin
            q.delete();
            m_pc = rp;
        end else begin
            if (q.size() > 0 && !s) void'(q.pop_front());
            if (req_now && a) begin
                e.pc  = m_pc;
                e.ins = mem[m_pc];
                q.push_back(e);
                m_pc = m_pc + 1'b1;
            end
        end
        m_idle = 1'b0;
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset();
        rst                 = 1'b1;
        stall               = 1'b1;
        redirect            = 1'b0;
        redirect_pc         = 8'h5A;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 16'hFFFF;
        @(posedge clk);
        @(negedge clk);
        q.delete();
        m_pc   = RST_PC;
        m_idle = 1'b1;
        check("rst_id_instr", id_instr, 16'h0000);
        check("rst_id_pc", id_pc, 8'h00);
        check("rst_opcode", opcode, 5'd0);
        check("rst_imm_5or8", imm_5or8, 1'b0);
        compare_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h2805;
        mem[1] = 16'hA8A5;

        do_reset();
        check("rst_req", imem_bus.imem_req, 1'b0);
        check("rst_addr", imem_bus.imem_addr, RST_PC);

        // Leave IDLE, then stream two known words back-to-back.
        cycle(0, 0, 0, 0);
        check("first_req", imem_bus.imem_req, 1'b1);
        cycle(1, 0, 0, 0);
        check("w0_instr", id_instr, 16'h2805);
        check("w0_imm5", imm_5b, 5'b00101);
        check("w0_5or8", imm_5or8, 1'b0);
        cycle(1, 0, 0, 0);
        check("w1_instr", id_instr, 16'hA8A5);
        check("w1_imm8", imm_8b, 8'hA5);
        check("w1_5or8", imm_5or8, 1'b1);
        check("w1_pc", id_pc, 8'h01);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);

        // Ack delayed three cycles at address 4.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0);
            check("wait_addr", imem_bus.imem_addr, 8'h04);
            check("wait_valid", id_valid, 1'b0);
        end
        cycle(1, 0, 0, 0);
        check("late_pc", id_pc, 8'h04);

        // Stall with a new ack: word goes to the skid, requests stop.
        cycle(1, 1, 0, 0);
        check("full_req", imem_bus.imem_req, 1'b0);
        check("full_hold_pc", id_pc, 8'h04);
        cycle(0, 1, 0, 0);
        cycle(0, 0, 0, 0);
        check("skid_pc", id_pc, 8'h05);
        check("resume_addr", imem_bus.imem_addr, 8'h06);

        // Redirect with the skid full and an ack in the same cycle.
        cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 8'h40);
        check("redir_valid", id_valid, 1'b0);
        check("redir_addr", imem_bus.imem_addr, 8'h40);
        cycle(1, 0, 0, 0);
        check("redir_pc", id_pc, 8'h40);

        // PC wrap from all-ones.
        cycle(0, 0, 1, 8'hFF);
        cycle(1, 0, 0, 0);
        check("wrap_addr", imem_bus.imem_addr, 8'h00);
        check("wrap_pc", id_pc, 8'hFF);

        // Reset while FULL and stalled.
        cycle(1, 0, 0, 0);
        cycle(1, 1, 0, 0);
        check("pre_rst_req", imem_bus.imem_req, 1'b0);
        do_reset();
        check("rst_full_valid", id_valid, 1'b0);
        cycle(0, 1, 0, 0);
        check("post_rst_addr", imem_bus.imem_addr, RST_PC);
        check("post_rst_req", imem_bus.imem_req, 1'b1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle($urandom_range(0, 9) < 7,
                      $urandom_range(0, 9) < 3,
                      $urandom_range(0, 39) == 0,
                      8'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_decode_stage.md
Name: fetch_decode_stage

Overview:
- Instruction-fetch and IF/ID stage of the 16-bit FPGA RISC core.
- Owns the PC and drives the instruction-memory request/acknowledge handshake.
- Holds the fetched word in the IF/ID register and splits it into the fields consumed by decode. Its imm_8b, imm_5b and imm_5or8 outputs feed the sign-extend unit directly.
- Absorbs downstream stalls with a one-entry skid buffer and supports branch/jump redirect.

Parameters:
- ADDR_W, 8, PC and instruction-memory word-address width.
- RESET_PC, 0, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  out  ADDR_W  word address presented to instruction memory; equals PC.
- imem_req  out  1  fetch request.
- imem_ack  in  1  imem_rdata is valid for the current imem_addr this cycle.
- imem_rdata  in  16  instruction word.
- stall  in  1  decode cannot accept; the IF/ID register must hold.
- redirect  in  1  branch/jump taken; flush and refetch.
- redirect_pc  in  ADDR_W  new fetch address.
- id_valid  out  1  IF/ID holds a live instruction.
- id_pc  out  ADDR_W  address of the instruction in IF/ID.
- id_instr  out  16  raw instruction.
- opcode  out  5  id_instr[15:11].
- rd  out  3  id_instr[10:8].
- rs  out  3  id_instr[7:5].
- imm_8b  out  8  id_instr[7:0].
- imm_5b  out  5  id_instr[4:0].
- imm_5or8  out  1  id_instr[15]; 1 selects the 8-bit immediate format.

Behaviour:
- Reset:
  - PC=RESET_PC; state=IDLE; imem_req=0.
  - id_valid=0, id_instr=0, id_pc=0, so all field outputs are 0.
  - Skid buffer is empty.
- Field outputs are pure combinational slices of id_instr. No extra latency.
- FSM states:
  - IDLE: entered only from reset. Moves to REQ on the next cycle.
  - REQ: imem_req=1.
    - On imem_ack with the IF/ID slot free (id_valid=0 or stall=0): load id_instr=imem_rdata, id_pc=PC, id_valid=1; PC=PC+1; stay in REQ.
    - On imem_ack with the slot blocked (id_valid=1 and stall=1): capture word and PC into the skid buffer; PC=PC+1; go to FULL.
    - With no ack: PC unchanged; keep requesting.
  - FULL: imem_req=0. When stall=0, move skid to IF/ID (id_valid=1), empty the skid, return to REQ.
- IF/ID drain:
  - id_valid=1 and stall=0 with no new word arriving: id_valid clears next cycle.
  - A new word in the same cycle replaces the old one back-to-back.
  - Sustained throughput is 1 instruction/cycle when imem_ack is held high.
- Redirect has the highest priority over everything in the same cycle:
  - PC=redirect_pc; id_valid=0; skid emptied; any imem_rdata acked that cycle is discarded; state=REQ.
  - The first fetch from redirect_pc is presented on the next cycle.
  - A redirect applies even while stall=1.
- PC arithmetic: word addressed, increment by 1, wraps modulo 2^ADDR_W (all-ones wraps to 0).
- While id_valid=1 and stall=1, id_instr and id_pc must not change.
- An acked word is never lost or duplicated unless discarded by redirect.
- rst=1 in any state, including mid-request or FULL, returns to the reset values on the next edge. Any in-flight ack in that cycle is ignored.

Test Plan:
- Reset, then imem_ack=1 with rdata sequence 0x2805, 0xA8A5 -> imem_addr 0,1,2...; id_instr=0x2805 with imm_5b=5'b00101, imm_5or8=0; next cycle id_instr=0xA8A5 with imm_8b=8'hA5, imm_5or8=1, id_pc=1.
- Ack delayed 3 cycles at addr 4 -> imem_req held and imem_addr stays 4; id_valid=0 during the wait; word lands in IF/ID one cycle after ack.
- stall=1 while id_valid=1 and a new ack arrives -> IF/ID unchanged; state FULL; imem_req=0; stall drop -> skid word appears in the next cycle with correct id_pc, then fetching resumes at the next PC.
- redirect=1 with redirect_pc=0x40 in the same cycle as ack, with skid full -> acked data dropped, id_valid=0, skid emptied; next imem_addr=0x40; first valid id_pc=0x40.
- PC=0xFF with ack (ADDR_W=8) -> next imem_addr=0x00; id_pc=0xFF for that word.
- rst asserted while in FULL with stall=1 -> next cycle: id_valid=0, imem_req=0, outputs 0; two cycles later imem_addr=RESET_PC with imem_req=1.
